// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the datapath ALU blocks.
//   OP_ADD/OP_ADC/OP_SUB/OP_SBB : 2-bit operation encodings
//   flags_t                     : flag bundle, ordered {cout, ovf, zero, neg}
//   carry_into()                : fully expanded lookahead carry helper
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_ADC = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_SBB = 2'b11;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
        logic neg;
    } flags_t;

    // Carry into position n of a generate/propagate chain, written as the
    // flat sum-of-products form (g[m] & p[m+1..n-1]) | (cin & p[0..n-1]),
    // so no term depends on another computed carry. Chains are at most 32
    // positions long.
    function automatic logic carry_into(input logic [31:0] g,
                                        input logic [31:0] p,
                                        input logic        cin,
                                        input int          n);
        logic c;
        logic term;
        c = cin;
        for (int i = 0; i < n; i++) begin
            c = c & p[i[4:0]];
        end
        for (int m = 0; m < n; m++) begin
            term = g[m[4:0]];
            for (int i = m + 1; i < n; i++) begin
                term = term & p[i[4:0]];
            end
            c = c | term;
        end
        return c;
    endfunction

endpackage

// File: rtl/cla_pipe_addsub_group.sv
// cla_group: one GROUP-bit carry-lookahead group.
//   a, b  : group operand bits
//   cin   : group carry-in (feeds bit 0)
//   sum   : group sum bits
//   gen   : group generate (carry out regardless of cin)
//   prop  : group propagate (every bit propagates)
//   cout  : group carry-out for the supplied cin
module cla_group
    import alu_pkg::*;
#(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] sum,
    output logic             gen,
    output logic             prop,
    output logic             cout
);

    logic [31:0] bit_g;
    logic [31:0] bit_p;

    // Bit generate/propagate depend only on the operands. They are kept
    // apart from the cin-dependent logic so that the group G/P can feed
    // the stage lookahead without forming a combinational loop.
    always_comb begin
        bit_g            = '0;
        bit_p            = '0;
        bit_g[GROUP-1:0] = a & b;
        bit_p[GROUP-1:0] = a ^ b;
    end

    assign gen  = carry_into(bit_g, bit_p, 1'b0, GROUP);
    assign prop = &bit_p[GROUP-1:0];
    assign cout = carry_into(bit_g, bit_p, cin, GROUP);

    for (genvar i = 0; i < GROUP; i++) begin : g_bit
        assign sum[i] = bit_p[i] ^ carry_into(bit_g, bit_p, cin, i);
    end

endmodule

// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: pipelined carry-lookahead adder/subtractor.
// Each stage resolves GROUPS_PER_STAGE lookahead groups; the carry between
// stages is registered. Latency is NSTAGE = WIDTH/(GROUP*GROUPS_PER_STAGE)
// cycles at one operation per cycle. WIDTH must be a multiple of
// GROUP*GROUPS_PER_STAGE, and GROUP and GROUPS_PER_STAGE must not exceed 32.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : request handshake
//   in_op                 : ADD/ADC/SUB/SBB (alu_pkg encodings)
//   in_a, in_b, in_cin    : operands; in_cin is carry (ADC) or borrow (SBB)
//   out_valid/out_ready   : result handshake
//   out_sum               : result, modulo 2^WIDTH
//   out_cout              : carry out of the MSB (1 = no borrow when subtracting)
//   out_ovf, out_zero, out_neg : signed overflow, zero, sign
module cla_pipe_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH            = 32,
    parameter int GROUP            = 4,
    parameter int GROUPS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg
);

    localparam int GPS    = GROUPS_PER_STAGE;
    localparam int SLICE  = GROUP * GPS;
    localparam int NSTAGE = WIDTH / SLICE;
    localparam int LAST   = NSTAGE - 1;

    // Pipeline rank k holds the operation that stage k works on. a_q/b_q
    // carry the full operands, so the slices not yet processed form the
    // skew path; s_q accumulates the finished slices as the deskew path.
    logic             v_q [NSTAGE];
    logic [WIDTH-1:0] a_q [NSTAGE];
    logic [WIDTH-1:0] b_q [NSTAGE];
    logic [WIDTH-1:0] s_q [NSTAGE];
    logic             c_q [NSTAGE];
    logic             z_q [NSTAGE];

    logic [SLICE-1:0] st_sum  [NSTAGE];
    logic [GPS-1:0]   st_gen  [NSTAGE];
    logic [GPS-1:0]   st_prop [NSTAGE];
    logic [GPS-1:0]   st_cin  [NSTAGE];
    logic             st_cout [NSTAGE];
    logic [WIDTH-1:0] s_done  [NSTAGE];

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic             msb_cin;
    flags_t           flags_q;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Subtraction is a + ~b + 1; with borrow-in the +1 becomes ~borrow.
    always_comb begin
        b_eff = in_b;
        c_eff = 1'b0;
        case (in_op)
            OP_ADD: begin
                b_eff = in_b;
                c_eff = 1'b0;
            end
            OP_ADC: begin
                b_eff = in_b;
                c_eff = in_cin;
            end
            OP_SUB: begin
                b_eff = ~in_b;
                c_eff = 1'b1;
            end
            OP_SBB: begin
                b_eff = ~in_b;
                c_eff = ~in_cin;
            end
            default: begin
                b_eff = in_b;
                c_eff = 1'b0;
            end
        endcase
    end

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        localparam logic [WIDTH-1:0] MASK = WIDTH'({SLICE{1'b1}}) << (k * SLICE);

        // Merge this stage's freshly computed slice into the finished bits.
        assign s_done[k] = (s_q[k] & ~MASK) | (WIDTH'(st_sum[k]) << (k * SLICE));

        for (genvar j = 0; j < GPS; j++) begin : g_grp
            localparam int LSB = k * SLICE + j * GROUP;

            // Group carry-ins come from the stage carry and the group G/P
            // of the lower groups, flattened rather than rippled.
            assign st_cin[k][j] = carry_into(32'(st_gen[k]), 32'(st_prop[k]), c_q[k], j);

            if (j == GPS - 1) begin : g_top
                cla_group #(.GROUP(GROUP)) u_grp (
                    .a    (a_q[k][LSB +: GROUP]),
                    .b    (b_q[k][LSB +: GROUP]),
                    .cin  (st_cin[k][j]),
                    .sum  (st_sum[k][j*GROUP +: GROUP]),
                    .gen  (st_gen[k][j]),
                    .prop (st_prop[k][j]),
                    .cout (st_cout[k])
                );
            end else begin : g_low
                // Carries inside the stage come from the lookahead above,
                // so only the topmost group's carry-out is consumed.
                logic cout_unused;
                cla_group #(.GROUP(GROUP)) u_grp (
                    .a    (a_q[k][LSB +: GROUP]),
                    .b    (b_q[k][LSB +: GROUP]),
                    .cin  (st_cin[k][j]),
                    .sum  (st_sum[k][j*GROUP +: GROUP]),
                    .gen  (st_gen[k][j]),
                    .prop (st_prop[k][j]),
                    .cout (cout_unused)
                );
            end
        end

        if (k == 0) begin : g_entry
            // Rank 0 captures the conditioned request; bubbles are loaded
            // too, since every rank moves together on advance.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q[0] <= 1'b0;
                    a_q[0] <= '0;
                    b_q[0] <= '0;
                    s_q[0] <= '0;
                    c_q[0] <= 1'b0;
                    z_q[0] <= 1'b0;
                end else if (advance) begin
                    v_q[0] <= in_valid;
                    a_q[0] <= in_a;
                    b_q[0] <= b_eff;
                    s_q[0] <= '0;
                    c_q[0] <= c_eff;
                    z_q[0] <= 1'b1;
                end
            end
        end else begin : g_rank
            // Pass the operation on with its slice result, registered carry
            // and running zero-AND.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q[k] <= 1'b0;
                    a_q[k] <= '0;
                    b_q[k] <= '0;
                    s_q[k] <= '0;
                    c_q[k] <= 1'b0;
                    z_q[k] <= 1'b0;
                end else if (advance) begin
                    v_q[k] <= v_q[k-1];
                    a_q[k] <= a_q[k-1];
                    b_q[k] <= b_q[k-1];
                    s_q[k] <= s_done[k-1];
                    c_q[k] <= st_cout[k-1];
                    z_q[k] <= z_q[k-1] & ~|st_sum[k-1];
                end
            end
        end
    end

    // Carry into the MSB recovered from its propagate bit and sum bit.
    assign msb_cin = a_q[LAST][WIDTH-1] ^ b_q[LAST][WIDTH-1] ^ s_done[LAST][WIDTH-1];

    // Output register; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            flags_q   <= '0;
        end else if (advance) begin
            out_valid     <= v_q[LAST];
            out_sum       <= s_done[LAST];
            flags_q.cout  <= st_cout[LAST];
            flags_q.ovf   <= msb_cin ^ st_cout[LAST];
            flags_q.zero  <= z_q[LAST] & ~|st_sum[LAST];
            flags_q.neg   <= s_done[LAST][WIDTH-1];
        end
    end

    assign out_cout = flags_q.cout;
    assign out_ovf  = flags_q.ovf;
    assign out_zero = flags_q.zero;
    assign out_neg  = flags_q.neg;

endmodule

// File: doc/cla_pipe_addsub.md
Name: cla_pipe_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the datapath ALU. It generalises the fixed 4-bit lookahead adder to WIDTH bits.
- The operand is split into GROUP-bit lookahead groups. GROUPS_PER_STAGE groups are resolved per clock, and the inter-stage carry is registered.
- Supports ADD/ADC/SUB/SBB and returns carry, overflow, zero and negative flags.
- Uses a valid/ready handshake, so it can sit between the register-read and writeback stages under back-pressure.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of GROUP*GROUPS_PER_STAGE.
- GROUP, 4, bits per lookahead group (full internal lookahead within a group).
- GROUPS_PER_STAGE, 2, groups chained combinationally (group G/P lookahead) per pipeline stage.
- Derived constant NSTAGE = WIDTH/(GROUP*GROUPS_PER_STAGE). This is the latency in cycles.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, request valid.
- in_ready, output, 1, request accepted when in_valid && in_ready.
- in_op, input, 2, operation: 00 ADD, 01 ADC, 10 SUB, 11 SBB.
- in_a, input, WIDTH, operand A.
- in_b, input, WIDTH, operand B.
- in_cin, input, 1, carry-in for ADC, or borrow-in for SBB; ignored for ADD/SUB.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accepts the result.
- out_sum, output, WIDTH, result.
- out_cout, output, 1, raw carry out of the MSB (for SUB/SBB: 1 = no borrow).
- out_ovf, output, 1, signed overflow.
- out_zero, output, 1, out_sum == 0.
- out_neg, output, 1, out_sum[WIDTH-1].

Behaviour:
- Operand conditioning at acceptance:
  - b_eff = in_b for ADD/ADC, ~in_b for SUB/SBB.
  - c_eff is 0 for ADD, in_cin for ADC, 1 for SUB, ~in_cin for SBB.
- Stage k (0..NSTAGE-1) computes sum bits for slice k from the delayed a and b_eff slices and the registered carry from stage k-1 (c_eff for stage 0).
- Within a group: g = a&b, p = a^b, c[i+1] = g[i] | p[i]&c[i] fully expanded, sum[i] = p[i]^c[i]. Bit 0 of every group includes the group carry-in.
- Groups inside a stage are chained by group G/P lookahead, not ripple.
- Slices not yet processed travel in skew registers. Completed slices travel in deskew registers, so all WIDTH bits reach the output together.
- A running zero-AND and the MSB carry-in are carried alongside the data.
- Last stage:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry-in(bit WIDTH-1) ^ cout.
  - zero = AND of all slice-zero bits.
  - neg = sum MSB.
- Latency: a request accepted at edge t appears with out_valid=1 after edge t+NSTAGE, if not stalled.
- Throughput: one operation per cycle.
- Flow control: advance = !out_valid || out_ready, and in_ready = advance (combinational).
  - When advance=0, every pipeline register holds. Bubbles are not collapsed.
  - Each stage carries a valid bit. Data in invalid stages is don't-care but must not cause X on flags; registers reset to 0.
- Outputs are registered and held stable while out_valid && !out_ready.
- Reset (asynchronous, any time):
  - All stage valids = 0, out_valid = 0.
  - out_sum = 0, out_cout/out_ovf/out_neg = 0, out_zero = 0.
  - In-flight operations are discarded.
  - in_ready = 1 in the first cycle after release.
- Simultaneous accept and output handshake in the same cycle is legal; the pipeline advances by one.
- Wrap-around: the sum is modulo 2^WIDTH; the carry is reported only via out_cout.

Decomposition:
- Shared package alu_pkg:
  - op encodings OP_ADD/OP_ADC/OP_SUB/OP_SBB (2-bit).
  - Flag bundle ordering {cout, ovf, zero, neg}.
- One sub-module: cla_group (GROUP-bit lookahead group). It outputs sum, group generate G, group propagate P and carry-out. Instantiate it WIDTH/GROUP times.
- Skew/deskew and valid registers are built with generate loops in the top module.

Test Plan (WIDTH=32, GROUP=4, GROUPS_PER_STAGE=2, so NSTAGE=4):
- ADD 0xFFFFFFFF + 0x00000001, out_ready=1 -> after 4 cycles: sum=0x00000000, cout=1, zero=1, ovf=0, neg=0. The carry crosses all stages.
- SUB 0x80000000 - 0x00000001 -> sum=0x7FFFFFFF, cout=1, ovf=1, neg=0.
- SBB 0x00000005, 0x00000005, in_cin=1 -> sum=0xFFFFFFFF, cout=0, neg=1, zero=0.
- Back-to-back stream of 8 ADCs with out_ready toggling 1,0,0,1 -> every result is correct and in order, outputs hold while stalled, none are dropped or duplicated, and in_ready == out_ready whenever out_valid=1.
- Assert rst_n low while 3 operations are in flight -> out_valid=0 immediately. After release no stale result appears, and a new ADD 0x7FFFFFFF+1 gives sum=0x80000000, ovf=1, neg=1.
- Random stress of 10k operations against a behavioural a±b model with random valid/ready -> all sums and flags match.
